// File: rtl/tbird_input_cond.sv
// Input conditioning for the T-bird turn-signal controller: synchronizes and
// debounces the pushbutton and two switches, then derives step/left/right/hazard.
module tbird_input_cond_chan #(
    parameter int   DEBOUNCE_CYCLES = 4,
    parameter int   CNT_W           = 20,
    parameter logic RST_VAL         = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic i_raw,
    output logic o_db,
    output logic o_fall
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_db;
    logic [CNT_W-1:0] r_cnt;
    logic             w_differ;
    logic             w_done;

    assign w_differ = (r_sync2 != r_db);
    assign w_done   = w_differ && (r_cnt == LAST);
    assign o_db     = r_db;
    // Qualifying a 1->0 transition at this edge.
    assign o_fall   = w_done && r_db;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sync1 <= RST_VAL;
            r_sync2 <= RST_VAL;
            r_db    <= RST_VAL;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_raw;
            r_sync2 <= r_sync1;
            if (!w_differ) begin
                r_cnt <= '0;
            end else if (w_done) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end
endmodule

module tbird_input_cond #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       key_n,
    input  logic       sw_left,
    input  logic       sw_right,
    output logic       step,
    output logic       left,
    output logic       right,
    output logic       hazard,
    output logic [7:0] press_cnt
);
    // Channel 0 = key (idles released = 1), 1 = left switch, 2 = right switch.
    logic [2:0] w_raw;
    logic [2:0] w_db;
    logic [2:0] w_fall;
    logic       w_unused_fall;
    logic       r_step;
    logic [7:0] r_press_cnt;

    assign w_raw = {sw_right, sw_left, key_n};

    for (genvar g = 0; g < 3; g++) begin : g_chan
        tbird_input_cond_chan #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W),
            .RST_VAL        (g == 0)
        ) u_chan (
            .clk   (clk),
            .reset (reset),
            .i_raw (w_raw[g]),
            .o_db  (w_db[g]),
            .o_fall(w_fall[g])
        );
    end

    // Switch channels have no edge consumer.
    assign w_unused_fall = |w_fall[2:1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_step      <= 1'b0;
            r_press_cnt <= '0;
        end else begin
            r_step <= w_fall[0];
            if (w_fall[0]) r_press_cnt <= r_press_cnt + 8'd1;
        end
    end

    assign step      = r_step;
    assign press_cnt = r_press_cnt;
    assign left      = w_db[1] & ~w_db[2];
    assign right     = w_db[2] & ~w_db[1];
    assign hazard    = w_db[1] &  w_db[2];
endmodule

// File: tb/tb_tbird_input_cond.sv
// Self-checking bench for tbird_input_cond: directed scenarios plus random
// bouncy inputs against a sample-history reference model.
module tb_tbird_input_cond;
    localparam int D = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       key_n = 1'b1;
    logic       sw_left = 1'b0;
    logic       sw_right = 1'b0;
    logic       step, left, right, hazard;
    logic [7:0] press_cnt;

    int n_chk = 0;
    int n_pass = 0;
    int n_fail = 0;
    int steps_seen = 0;

    // Model: raw samples taken at each edge since reset (newest first), and
    // the debounced level per channel.
    bit hist[3][$];
    bit mdb[3];
    bit m_step;
    int m_press;

    tbird_input_cond #(.DEBOUNCE_CYCLES(D), .CNT_W(20)) dut (
        .clk(clk), .reset(reset), .key_n(key_n), .sw_left(sw_left),
        .sw_right(sw_right), .step(step), .left(left), .right(right),
        .hazard(hazard), .press_cnt(press_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int c = 0; c < 3; c++) begin
            hist[c].delete();
            repeat (D + 1) hist[c].push_front(c == 0);
            mdb[c] = (c == 0);
        end
        m_step  = 0;
        m_press = 0;
    endtask

    // A debounced level flips once the last D values seen by the second
    // synchronizer stage all disagree with it; those are the samples taken
    // 2..D+1 edges ago.
    task automatic model_edge(input bit [2:0] raw);
        bit all_diff;
        m_step = 0;
        for (int c = 0; c < 3; c++) begin
            all_diff = 1;
            for (int j = 1; j <= D; j++) if (hist[c][j] == mdb[c]) all_diff = 0;
            if (all_diff) begin
                mdb[c] = !mdb[c];
                if (c == 0 && mdb[0] == 0) begin
                    m_step  = 1;
                    m_press = (m_press + 1) % 256;
                end
            end
            hist[c].push_front(raw[c]);
            void'(hist[c].pop_back());
        end
    endtask

    task automatic check_all();
        check("step", {7'd0, step}, {7'd0, m_step});
        check("left", {7'd0, left}, {7'd0, mdb[1] & !mdb[2]});
        check("right", {7'd0, right}, {7'd0, mdb[2] & !mdb[1]});
        check("hazard", {7'd0, hazard}, {7'd0, mdb[1] & mdb[2]});
        check("press_cnt", press_cnt, m_press[7:0]);
        check("onehot0", {7'd0, $onehot0({left, right, hazard})}, 8'd1);
    endtask

    task automatic tick();
        bit [2:0] raw;
        @(posedge clk);
        raw = {sw_right, sw_left, key_n};
        if (!reset) model_edge(raw);
        #1;
        check_all();
        if (step) steps_seen++;
    endtask

    // Assert reset between edges, hold it across n edges, release at a negedge.
    task automatic async_reset(input int n);
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        check_all();
        repeat (n) tick();
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        model_reset();
        #1;
        check_all();
        repeat (2) tick();
        @(negedge clk);
        reset = 1'b0;

        // Held press: one step right after edge 6, count 0 -> 1, no repeat.
        key_n = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("hold_step_e%0d", i), {7'd0, step}, (i == 6) ? 8'd1 : 8'd0);
        end
        repeat (12) tick();
        check("hold_press_cnt", press_cnt, 8'd1);
        key_n = 1'b1;
        repeat (8) tick();

        // Short 3-cycle bounces never qualify.
        async_reset(2);
        repeat (5) begin
            key_n = 1'b0;
            repeat (3) tick();
            key_n = 1'b1;
            repeat (5) tick();
        end
        check("bounce_press_cnt", press_cnt, 8'd0);

        // left -> hazard -> right.
        sw_left = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("left_e%0d", i), {7'd0, left}, (i == 6) ? 8'd1 : 8'd0);
        end
        sw_right = 1'b1;
        repeat (5) tick();
        check("left_before_hazard", {7'd0, left}, 8'd1);
        tick();
        check("hazard_e6", {7'd0, hazard}, 8'd1);
        check("left_off_at_hazard", {7'd0, left}, 8'd0);
        sw_left = 1'b0;
        repeat (8) tick();
        check("right_after_left_drop", {7'd0, right}, 8'd1);

        // Reset mid-qualification discards the partial count.
        sw_right = 1'b0;
        async_reset(2);
        sw_right = 1'b1;
        repeat (4) tick();
        async_reset(2);
        for (int i = 1; i <= 6; i++) begin
            tick();
            check($sformatf("right_after_rst_e%0d", i), {7'd0, right}, (i == 6) ? 8'd1 : 8'd0);
        end

        // Key and left switch qualify on the same edge.
        sw_right = 1'b0;
        async_reset(2);
        key_n   = 1'b0;
        sw_left = 1'b1;
        repeat (6) tick();
        check("same_edge_step", {7'd0, step}, 8'd1);
        check("same_edge_left", {7'd0, left}, 8'd1);
        key_n   = 1'b1;
        sw_left = 1'b0;
        repeat (8) tick();

        // 256 clean presses wrap the counter to 0.
        async_reset(2);
        steps_seen = 0;
        repeat (256) begin
            key_n = 1'b0;
            repeat (10) tick();
            key_n = 1'b1;
            repeat (10) tick();
        end
        check("wrap_steps", steps_seen[7:0], 8'd0);
        check("wrap_steps_hi", steps_seen[15:8], 8'd1);
        check("wrap_press_cnt", press_cnt, 8'd0);

        // Random bouncy inputs with occasional asynchronous resets.
        repeat (3000) begin
            if ($urandom_range(7) == 0) key_n = ~key_n;
            if ($urandom_range(9) == 0) sw_left = ~sw_left;
            if ($urandom_range(9) == 0) sw_right = ~sw_right;
            if ($urandom_range(599) == 0) async_reset($urandom_range(3, 1));
            else tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/tbird_input_cond.md
TBIRD_INPUT_COND -- requirements
Module: tbird_input_cond

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: number of consecutive cycles a synchronized input must differ from its debounced value before the debounced value changes; legal range 1..2^CNT_W-1.
REQ-002 Parameter CNT_W, default 20: width of each debounce counter (board builds use DEBOUNCE_CYCLES=500000).
REQ-003 Port clk, input, 1 bit: sole clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high; clears all state immediately regardless of clk.
REQ-005 Port key_n, input, 1 bit: raw pushbutton, active-low (0 = pressed), asynchronous to clk, bouncy.
REQ-006 Port sw_left, input, 1 bit: raw left-turn switch, asynchronous, bouncy.
REQ-007 Port sw_right, input, 1 bit: raw right-turn switch, asynchronous, bouncy.
REQ-008 Port step, output, 1 bit: one-cycle pulse per qualified button press; serves as the advance enable of the downstream turn-signal FSM.
REQ-009 Port left, output, 1 bit: qualified left request (left only).
REQ-010 Port right, output, 1 bit: qualified right request (right only).
REQ-011 Port hazard, output, 1 bit: both switches qualified high.
REQ-012 Port press_cnt, output, 8 bits: count of step pulses since reset.

Function
REQ-013 Each raw input SHALL pass through its own two-flop synchronizer; no logic reads a raw input or the first synchronizer flop.
REQ-014 Each of the three channels SHALL have an independent debounced register db and a CNT_W-bit counter cnt.
REQ-015 Per channel, per edge: if sync2 == db then cnt <= 0; else if cnt == DEBOUNCE_CYCLES-1 then db <= sync2 and cnt <= 0; else cnt <= cnt+1.
REQ-016 Any cycle in which sync2 returns to db (bounce) SHALL zero cnt; qualification restarts from 0.
REQ-017 Latency: with a raw input held at a new value, db SHALL change at the (DEBOUNCE_CYCLES+2)th rising edge, counting the first edge that samples the new value as edge 1 (edge 6 for the default).
REQ-018 step SHALL be a registered output, high for exactly the one cycle following the edge at which key db transitions 1->0; releases (0->1) SHALL produce no pulse.
REQ-019 A held button SHALL produce exactly one step; no auto-repeat.
REQ-020 left = dbL AND NOT dbR; right = dbR AND NOT dbL; hazard = dbL AND dbR; at most one of the three is high in any cycle.
REQ-021 left/right/hazard SHALL be decoded from db registers only (no raw or synchronizer terms), so they change only on clk edges.
REQ-022 press_cnt SHALL increment by 1 at the same edge that asserts step, wrapping 255 -> 0 with no flag.
REQ-023 Channels are independent: simultaneous qualification on several channels SHALL update each db at the same edge with no priority.

Reset
REQ-024 On reset assertion: key sync flops and key db = 1 (released); switch sync flops and dbL/dbR = 0; all cnt = 0; step = 0; press_cnt = 0; hence left = right = hazard = 0.
REQ-025 Reset asserted mid-qualification SHALL discard partial counts; after release an input held throughout still requires the full REQ-017 latency.
REQ-026 A key held pressed across reset release SHALL produce one step after qualification (db resets to released).

Verification
REQ-027 Reset, key_n=0 held from edge 1 -> step high only in the cycle after edge 6, press_cnt 0->1, no further pulse while held.
REQ-028 key_n pulses 0 for 3 cycles then 1, repeated 5 times -> step never asserts, press_cnt stays 0.
REQ-029 sw_left=1 held -> left=1 from edge 6; then sw_right=1 -> at its edge 6 left=0, hazard=1 in the same cycle; sw_left=0 -> right=1 after qualification.
REQ-030 256 clean presses (each held 10 cycles, released 10 cycles) -> 256 single-cycle step pulses, press_cnt ends at 0.
REQ-031 sw_right=1 held, reset asserted asynchronously at count 3 for 2 cycles -> right stays 0, asserts at edge 6 after reset release.
REQ-032 key_n and sw_left both driven 0->... (key pressed, left high) on the same edge -> step and left assert together on the edge-6 boundary.
